// File: rtl/alu_tx_pkg.sv
// Shared types and constants for the ALU result UART transmitter.
// The header byte carries a fixed tag so a receiver can resynchronise on it.
package alu_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam logic [4:0] HEADER_TAG = 5'b10100;
   localparam int         DATA_BITS  = 8;
   localparam int         MSG_BYTES  = 2;

   function automatic logic [7:0] header_byte(input logic [2:0] op);
      return {HEADER_TAG, op};
   endfunction

   function automatic logic [7:0] data_byte(input logic [5:0] result);
      return {2'b00, result};
   endfunction

endpackage

// File: rtl/alu_tx_baud.sv
// Bit timer: counts 0..CLKS_PER_BIT-1 while running and flags terminal count.
// A clear restarts the bit period so every frame begins on a full bit time.
module alu_tx_baud #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_run,
   output logic o_tick
);

   localparam int            CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] r_cnt;
   logic          w_tc;

   assign w_tc = (r_cnt == TC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_run) begin
         r_cnt <= w_tc ? '0 : r_cnt + 1'b1;
      end
   end

   assign o_tick = i_run & w_tc & ~i_clr;

endmodule

// File: rtl/alu_uart_tx.sv
// Sends {op,result} as a two-byte 8N1 UART message (header 0xA0+op, then result).
//  state | meaning
//  IDLE  | line high, waiting for start or an auto trigger
//  START | start bit (0) of the current byte
//  DATA  | 8 data bits, LSB first
//  STOP  | stop bit (1); chains to the next byte or finishes the message
module alu_uart_tx
   import alu_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [2:0] op,
   input  logic [5:0] result,
   input  logic       start,
   input  logic       auto_en,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic       LAST_BYTE = 1'(MSG_BYTES - 1);

   state_t     r_state,     w_state_nxt;
   logic [7:0] r_shift,     w_shift_nxt;
   logic [7:0] r_next_byte, w_next_byte_nxt;
   logic [2:0] r_bit_idx,   w_bit_idx_nxt;
   logic       r_byte_idx,  w_byte_idx_nxt;
   logic [8:0] r_last_sent, w_last_sent_nxt;
   logic       r_tx,        w_tx_nxt;
   logic       r_busy,      w_busy_nxt;
   logic       r_done,      w_done_nxt;

   logic       w_tick;
   logic       w_launch;
   logic       w_abort;

   assign w_launch = (r_state == IDLE) & ena &
                     (start | (auto_en & ({op, result} != r_last_sent)));
   assign w_abort  = (r_state != IDLE) & ~ena;

   alu_tx_baud #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_launch | w_abort),
      .i_run  (r_state != IDLE),
      .o_tick (w_tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_shift     <= '0;
         r_next_byte <= '0;
         r_bit_idx   <= '0;
         r_byte_idx  <= 1'b0;
         r_last_sent <= '0;
         r_tx        <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_shift     <= w_shift_nxt;
         r_next_byte <= w_next_byte_nxt;
         r_bit_idx   <= w_bit_idx_nxt;
         r_byte_idx  <= w_byte_idx_nxt;
         r_last_sent <= w_last_sent_nxt;
         r_tx        <= w_tx_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_shift_nxt     = r_shift;
      w_next_byte_nxt = r_next_byte;
      w_bit_idx_nxt   = r_bit_idx;
      w_byte_idx_nxt  = r_byte_idx;
      w_last_sent_nxt = r_last_sent;

      case (r_state)
         IDLE: begin
            if (w_launch) begin
               w_state_nxt     = START;
               w_shift_nxt     = header_byte(op);
               w_next_byte_nxt = data_byte(result);
               w_last_sent_nxt = {op, result};
               w_bit_idx_nxt   = '0;
               w_byte_idx_nxt  = 1'b0;
            end
         end
         START: begin
            if (w_tick) w_state_nxt = DATA;
         end
         DATA: begin
            if (w_tick) begin
               if (r_bit_idx == LAST_BIT) begin
                  w_state_nxt   = STOP;
                  w_bit_idx_nxt = '0;
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 3'd1;
                  w_shift_nxt   = {1'b0, r_shift[7:1]};
               end
            end
         end
         STOP: begin
            if (w_tick) begin
               if (r_byte_idx == LAST_BYTE) begin
                  w_state_nxt    = IDLE;
                  w_byte_idx_nxt = 1'b0;
               end else begin
                  w_state_nxt    = START;
                  w_byte_idx_nxt = r_byte_idx + 1'b1;
                  w_shift_nxt    = r_next_byte;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      // last_sent deliberately survives an abort so auto mode does not resend
      if (w_abort) begin
         w_state_nxt    = IDLE;
         w_bit_idx_nxt  = '0;
         w_byte_idx_nxt = 1'b0;
      end
   end

   // Outputs are precomputed from next-state values and registered.
   always_comb begin
      w_busy_nxt = (w_state_nxt != IDLE);
      w_done_nxt = (r_state == STOP) & w_tick & (r_byte_idx == LAST_BYTE) & ~w_abort;
      case (w_state_nxt)
         START:   w_tx_nxt = 1'b0;
         DATA:    w_tx_nxt = w_shift_nxt[0];
         default: w_tx_nxt = 1'b1;
      endcase
   end

   assign tx   = r_tx;
   assign busy = r_busy;
   assign done = r_done;

endmodule
